// File: rtl/global_pkg.sv
// global_pkg: shared arbiter state/owner types and default arbitration timing.
package global_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_CPU, ARB_DMA, ARB_TURN} arb_state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;
  localparam int RAM_ARB_MAX_HOLD_DEF = 16;
  localparam int RAM_ARB_TURN_DEF = 1;
endpackage

// File: rtl/ram_arb_mux.sv
// ram_arb_mux: selects the owner's strobe/address/data bundle onto the RAM pins.
module ram_arb_mux
  import global_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  arb_state_t      state,
  input  logic            cpu_cs,
  input  logic            cpu_wen,
  input  logic            cpu_oen,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_data,
  input  logic            dma_cs,
  input  logic            dma_wen,
  input  logic            dma_oen,
  input  logic [AW-1:0]   dma_addr,
  input  logic [DW-1:0]   dma_data,
  output logic            ram_cs,
  output logic            ram_wen,
  output logic            ram_oen,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_data
);
  logic cpu, dma;
  always_comb begin
    cpu = state == ARB_CPU;
    dma = state == ARB_DMA;
    ram_cs = cpu ? cpu_cs : dma ? dma_cs : 1'b0;
    ram_wen = cpu ? cpu_wen : dma ? dma_wen : 1'b1;
    ram_oen = cpu ? cpu_oen : dma ? dma_oen : 1'b1;
    ram_addr = cpu ? cpu_addr : dma ? dma_addr : '0;
    ram_data = cpu ? cpu_data : dma ? dma_data : '0;
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: CPU/DMA single-port RAM arbiter with hold limit and turnaround gap.
// RAM_ARB_STATS_EN adds grant and preemption counters.
module ram_arbiter
  import global_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MAX_HOLD = RAM_ARB_MAX_HOLD_DEF,
  parameter int TURN_CYC = RAM_ARB_TURN_DEF
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Cpu_Req,
  output logic          Cpu_Gnt,
  input  logic          Cpu_Cs,
  input  logic          Cpu_Wen,
  input  logic          Cpu_Oen,
  input  logic [AW-1:0] Cpu_Addr,
  input  logic [DW-1:0] Cpu_DataOut,
  input  logic          Dma_Req,
  output logic          Dma_Gnt,
  input  logic          Dma_Cs,
  input  logic          Dma_Wen,
  input  logic          Dma_Oen,
  input  logic [AW-1:0] Dma_Addr,
  input  logic [DW-1:0] Dma_DataOut,
  output logic          RAM_Cs,
  output logic          RAM_Wen,
  output logic          RAM_Oen,
  output logic [AW-1:0] RAM_Addr,
  output logic [DW-1:0] RAM_DataIn,
`ifdef RAM_ARB_STATS_EN
  output logic [15:0]   Cpu_Gnt_Cnt,
  output logic [15:0]   Dma_Gnt_Cnt,
  output logic [15:0]   Preempt_Cnt,
`endif
  output logic          Arb_Err
);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);
  localparam logic [1:0] TURN_MAX = 2'(TURN_CYC - 1);
  arb_state_t state, state_nxt;
  owner_t prio, prio_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [1:0] turn_cnt, turn_nxt;
  logic forced;
  always_comb begin
    state_nxt = state;
    prio_nxt = prio;
    forced = 1'b0;
    case (state)
      ARB_IDLE: state_nxt = Dma_Req ? ARB_DMA : Cpu_Req ? ARB_CPU : ARB_IDLE;
      ARB_CPU: begin
        forced = Cpu_Req && Dma_Req && hold_cnt == HOLD_MAX;
        if (!Cpu_Req || forced) begin
          state_nxt = ARB_TURN;
          prio_nxt = OWN_DMA;
        end
      end
      ARB_DMA: begin
        forced = Dma_Req && Cpu_Req && hold_cnt == HOLD_MAX;
        if (!Dma_Req || forced) begin
          state_nxt = ARB_TURN;
          prio_nxt = OWN_CPU;
        end
      end
      default:
        if (turn_cnt == TURN_MAX)
          state_nxt = prio == OWN_DMA ? (Dma_Req ? ARB_DMA : Cpu_Req ? ARB_CPU : ARB_IDLE)
                                      : (Cpu_Req ? ARB_CPU : Dma_Req ? ARB_DMA : ARB_IDLE);
    endcase
    hold_nxt = (state_nxt == state && (state == ARB_CPU || state == ARB_DMA))
             ? (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 8'd1) : 8'd0;
    turn_nxt = (state == ARB_TURN && state_nxt == ARB_TURN) ? turn_cnt + 2'd1 : 2'd0;
  end
  // Grants come straight from flops so the requesters never see decode glitches
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ARB_IDLE;
      prio <= OWN_CPU;
      hold_cnt <= '0;
      turn_cnt <= '0;
      Cpu_Gnt <= 1'b0;
      Dma_Gnt <= 1'b0;
      Arb_Err <= 1'b0;
    end else begin
      state <= state_nxt;
      prio <= prio_nxt;
      hold_cnt <= hold_nxt;
      turn_cnt <= turn_nxt;
      Cpu_Gnt <= state_nxt == ARB_CPU;
      Dma_Gnt <= state_nxt == ARB_DMA;
      Arb_Err <= Arb_Err | (Cpu_Cs & ~Cpu_Gnt) | (Dma_Cs & ~Dma_Gnt);
    end
  end
`ifdef RAM_ARB_STATS_EN
  logic cpu_start, dma_start;
  always_comb begin
    cpu_start = state_nxt == ARB_CPU && state != ARB_CPU;
    dma_start = state_nxt == ARB_DMA && state != ARB_DMA;
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Cpu_Gnt_Cnt <= '0;
      Dma_Gnt_Cnt <= '0;
      Preempt_Cnt <= '0;
    end else begin
      Cpu_Gnt_Cnt <= Cpu_Gnt_Cnt + 16'(cpu_start && ~&Cpu_Gnt_Cnt);
      Dma_Gnt_Cnt <= Dma_Gnt_Cnt + 16'(dma_start && ~&Dma_Gnt_Cnt);
      Preempt_Cnt <= Preempt_Cnt + 16'(forced && ~&Preempt_Cnt);
    end
  end
`endif
  ram_arb_mux #(.AW(AW), .DW(DW)) u_mux (
    .state(state),
    .cpu_cs(Cpu_Cs), .cpu_wen(Cpu_Wen), .cpu_oen(Cpu_Oen), .cpu_addr(Cpu_Addr), .cpu_data(Cpu_DataOut),
    .dma_cs(Dma_Cs), .dma_wen(Dma_Wen), .dma_oen(Dma_Oen), .dma_addr(Dma_Addr), .dma_data(Dma_DataOut),
    .ram_cs(RAM_Cs), .ram_wen(RAM_Wen), .ram_oen(RAM_Oen), .ram_addr(RAM_Addr), .ram_data(RAM_DataIn)
  );
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter with a RAM-write scoreboard.
module tb_ram_arbiter;
  import global_pkg::*;
  logic Clk = 1'b0;
  logic Rst_n;
  logic Cpu_Req, Cpu_Gnt, Cpu_Cs, Cpu_Wen, Cpu_Oen;
  logic [7:0] Cpu_Addr, Cpu_DataOut;
  logic Dma_Req, Dma_Gnt, Dma_Cs, Dma_Wen, Dma_Oen;
  logic [7:0] Dma_Addr, Dma_DataOut;
  logic RAM_Cs, RAM_Wen, RAM_Oen;
  logic [7:0] RAM_Addr, RAM_DataIn;
  logic Arb_Err;
`ifdef RAM_ARB_STATS_EN
  logic [15:0] Cpu_Gnt_Cnt, Dma_Gnt_Cnt, Preempt_Cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] sb[$];
  ram_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Cpu_Req(Cpu_Req), .Cpu_Gnt(Cpu_Gnt), .Cpu_Cs(Cpu_Cs), .Cpu_Wen(Cpu_Wen), .Cpu_Oen(Cpu_Oen),
    .Cpu_Addr(Cpu_Addr), .Cpu_DataOut(Cpu_DataOut),
    .Dma_Req(Dma_Req), .Dma_Gnt(Dma_Gnt), .Dma_Cs(Dma_Cs), .Dma_Wen(Dma_Wen), .Dma_Oen(Dma_Oen),
    .Dma_Addr(Dma_Addr), .Dma_DataOut(Dma_DataOut),
    .RAM_Cs(RAM_Cs), .RAM_Wen(RAM_Wen), .RAM_Oen(RAM_Oen), .RAM_Addr(RAM_Addr), .RAM_DataIn(RAM_DataIn),
`ifdef RAM_ARB_STATS_EN
    .Cpu_Gnt_Cnt(Cpu_Gnt_Cnt), .Dma_Gnt_Cnt(Dma_Gnt_Cnt), .Preempt_Cnt(Preempt_Cnt),
`endif
    .Arb_Err(Arb_Err)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask
  // Every RAM write seen on the pins must match the oldest queued expectation
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && RAM_Cs === 1'b1 && RAM_Wen === 1'b0) begin
      if (sb.size() == 0) chk("sb_unexpected_write", {16'h0, RAM_Addr, RAM_DataIn}, 32'hFFFF_FFFF);
      else chk("sb_write", {16'h0, RAM_Addr, RAM_DataIn}, {16'h0, sb.pop_front()});
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    Rst_n = 1'b0;
    {Cpu_Req, Cpu_Cs, Dma_Req, Dma_Cs} = '0;
    {Cpu_Wen, Cpu_Oen, Dma_Wen, Dma_Oen} = '1;
    {Cpu_Addr, Cpu_DataOut, Dma_Addr, Dma_DataOut} = '0;
    cyc();
    cyc();
    chk("rst_cpu_gnt", Cpu_Gnt, 0);
    chk("rst_dma_gnt", Dma_Gnt, 0);
    chk("rst_ram_cs", RAM_Cs, 0);
    chk("rst_ram_wen", RAM_Wen, 1);
    chk("rst_ram_oen", RAM_Oen, 1);
    chk("rst_ram_addr", RAM_Addr, 0);
    chk("rst_ram_data", RAM_DataIn, 0);
    chk("rst_err", Arb_Err, 0);
    Rst_n = 1'b1;
    cyc();
    Cpu_Req = 1'b1;
    cyc();
    chk("cpu_gnt_1edge", Cpu_Gnt, 1);
    chk("cpu_only_dma_gnt", Dma_Gnt, 0);
    Cpu_Cs = 1'b1; Cpu_Wen = 1'b0; Cpu_Addr = 8'h40; Cpu_DataOut = 8'h5A;
    sb.push_back({8'h40, 8'h5A});
    #1;
    chk("cpu_ram_addr", RAM_Addr, 8'h40);
    chk("cpu_ram_data", RAM_DataIn, 8'h5A);
    chk("cpu_ram_wen", RAM_Wen, 0);
    chk("cpu_ram_cs", RAM_Cs, 1);
    cyc();
    Cpu_Cs = 1'b0; Cpu_Wen = 1'b1; Cpu_Req = 1'b0;
    cyc();
    chk("turn_cpu_gnt", Cpu_Gnt, 0);
    chk("turn_ram_cs", RAM_Cs, 0);
    chk("turn_state", dut.state, ARB_TURN);
    cyc();
    chk("idle_after_turn", dut.state, ARB_IDLE);
    Cpu_Req = 1'b1;
    cyc();
    chk("cpu_regrant", Cpu_Gnt, 1);
    Cpu_Req = 1'b0;
    cyc();
    cyc();
    Cpu_Req = 1'b1; Dma_Req = 1'b1;
    cyc();
    chk("both_dma_wins", Dma_Gnt, 1);
    chk("both_cpu_waits", Cpu_Gnt, 0);
    Dma_Cs = 1'b1; Dma_Wen = 1'b0; Dma_Addr = 8'h81; Dma_DataOut = 8'h3C;
    sb.push_back({8'h81, 8'h3C});
    n = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      Dma_Cs = 1'b0; Dma_Wen = 1'b1;
      if (!Dma_Gnt) break;
      n++;
    end
    chk("hold_limit_cycles", n, 16);
    chk("preempt_turn_cpu_gnt", Cpu_Gnt, 0);
    chk("preempt_turn_ram_cs", RAM_Cs, 0);
    Dma_Req = 1'b0;
    cyc();
    chk("preempt_cpu_gnt", Cpu_Gnt, 1);
`ifdef RAM_ARB_STATS_EN
    chk("preempt_cnt", Preempt_Cnt, 1);
`endif
    Cpu_Req = 1'b0;
    cyc();
    cyc();
    Dma_Req = 1'b1;
    cyc();
    chk("burst_dma_gnt", Dma_Gnt, 1);
    Dma_Cs = 1'b1; Dma_Oen = 1'b0;
    #1;
    chk("burst_ram_cs", RAM_Cs, 1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_dma_gnt", Dma_Gnt, 0);
    chk("async_rst_ram_cs", RAM_Cs, 0);
    Dma_Cs = 1'b0; Dma_Oen = 1'b1; Dma_Req = 1'b0;
    cyc();
    Rst_n = 1'b1;
    cyc();
    chk("post_rst_state", dut.state, ARB_IDLE);
    chk("post_rst_hold", dut.hold_cnt, 0);
    chk("post_rst_turn", dut.turn_cnt, 0);
    chk("post_rst_err", Arb_Err, 0);
`ifdef RAM_ARB_STATS_EN
    chk("post_rst_cnts", {Cpu_Gnt_Cnt, Dma_Gnt_Cnt | Preempt_Cnt}, 0);
`endif
    Dma_Req = 1'b1;
    cyc();
    chk("alt_dma_first", Dma_Gnt, 1);
    for (int k = 0; k < 4; k++) begin
      Dma_Req = 1'b0; Cpu_Req = 1'b1;
      cyc();
      chk("alt_turn_a", {Cpu_Gnt, Dma_Gnt}, 0);
      cyc();
      chk("alt_cpu_gnt", Cpu_Gnt, 1);
      Cpu_Req = 1'b0;
      Dma_Req = k < 3;
      cyc();
      chk("alt_turn_b", {Cpu_Gnt, Dma_Gnt}, 0);
      cyc();
      chk("alt_dma_gnt", Dma_Gnt, k < 3);
    end
`ifdef RAM_ARB_STATS_EN
    chk("cpu_gnt_cnt", Cpu_Gnt_Cnt, 4);
    chk("dma_gnt_cnt", Dma_Gnt_Cnt, 4);
`endif
    Dma_Cs = 1'b1;
    #1;
    chk("viol_ram_cs", RAM_Cs, 0);
    chk("viol_err_before", Arb_Err, 0);
    cyc();
    chk("viol_err_set", Arb_Err, 1);
    Dma_Cs = 1'b0;
    cyc();
    cyc();
    chk("viol_err_sticky", Arb_Err, 1);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
